// File: rtl/lw_sha_ahb_adapter.sv
// AHB-Lite slave front end for the lightweight SHA/HMAC accelerator.
// Turns pipelined AHB-Lite transfers into single-cycle wr/rd strobes towards
// the SHA register/control block, waits for its handshakes, and folds slave
// errors, protocol violations and write-ack timeouts into the two-cycle AHB
// ERROR response.

`ifndef FIQSHA_BUS
`define FIQSHA_BUS 32
`endif

module lw_sha_ahb_adapter #(
    parameter int unsigned FIQSHA_BUS_DATA_WIDTH = `FIQSHA_BUS,
    parameter int unsigned ACK_TIMEOUT           = 4
) (
    input  logic                             clk_i,
    input  logic                             resetn_i,

    // AHB-Lite slave port
    input  logic                             hsel_i,
    input  logic [11:0]                      haddr_i,
    input  logic [1:0]                       htrans_i,
    input  logic                             hwrite_i,
    input  logic [2:0]                       hsize_i,
    input  logic [2:0]                       hburst_i,
    input  logic [FIQSHA_BUS_DATA_WIDTH-1:0] hwdata_i,
    input  logic                             hready_i,
    output logic                             hreadyout_o,
    output logic                             hresp_o,
    output logic [FIQSHA_BUS_DATA_WIDTH-1:0] hrdata_o,

    // Control block write side
    output logic                             wr_o,
    input  logic                             wr_ack_i,
    output logic [11:0]                      waddr_o,
    output logic [FIQSHA_BUS_DATA_WIDTH-1:0] wdata_o,
    input  logic                             slv_error_i,

    // Control block read side
    output logic                             rd_o,
    output logic [11:0]                      raddr_o,
    input  logic [FIQSHA_BUS_DATA_WIDTH-1:0] rdata_i,
    input  logic                             read_valid_i,
    output logic                             rd_ack_o,

    output logic [1:0]                       burst_type_o
);

    localparam int unsigned W        = FIQSHA_BUS_DATA_WIDTH;
    localparam int unsigned AW       = 12;
    localparam int unsigned SIZE_LOG = $clog2(W / 8);
    localparam int unsigned CNT_W    = $clog2(ACK_TIMEOUT + 1);

    localparam logic [2:0]       HSIZE_WORD = 3'(SIZE_LOG);
    localparam logic [AW-1:0]    ALIGN_MASK = AW'((1 << SIZE_LOG) - 1);
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(ACK_TIMEOUT - 1);

    localparam logic [1:0] TRANS_NONSEQ = 2'b10;
    localparam logic [1:0] TRANS_SEQ    = 2'b11;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_WR_ISSUE = 3'd1;
    localparam logic [2:0] ST_WR_WAIT  = 3'd2;
    localparam logic [2:0] ST_RD       = 3'd3;
    localparam logic [2:0] ST_ERR1     = 3'd4;
    localparam logic [2:0] ST_ERR2     = 3'd5;

    logic [2:0]       state_q,  state_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic [AW-1:0]    addr_q,   addr_d;
    logic [AW-1:0]    waddr_q,  waddr_d;
    logic [AW-1:0]    raddr_q,  raddr_d;
    logic [W-1:0]     wdata_q,  wdata_d;
    logic [W-1:0]     hrdata_q, hrdata_d;
    logic [1:0]       burst_q,  burst_d;
    logic             wr_q,     wr_d;
    logic             rd_q,     rd_d;
    logic             rd_ack_q, rd_ack_d;

    logic             ready_c;
    logic             resp_c;
    logic             accept_c;
    logic             trans_c;
    logic             viol_c;

    // Map AHB HBURST onto the control block's two-bit burst class.
    function automatic logic [1:0] enc_burst(input logic [2:0] hburst);
        case (hburst)
            3'd0:       enc_burst = 2'd0;
            3'd1:       enc_burst = 2'd1;
            3'd2, 3'd3: enc_burst = 2'd2;
            default:    enc_burst = 2'd3;
        endcase
    endfunction

    // Only NONSEQ/SEQ carry a transfer; BUSY and IDLE are left uncaptured.
    assign trans_c = (htrans_i == TRANS_NONSEQ) || (htrans_i == TRANS_SEQ);

    // Wrong size or a misaligned address is rejected before any strobe.
    assign viol_c  = (hsize_i != HSIZE_WORD) || ((haddr_i & ALIGN_MASK) != '0);

    // Next-state, handshake and address-phase capture logic.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        waddr_d  = waddr_q;
        raddr_d  = raddr_q;
        wdata_d  = wdata_q;
        hrdata_d = hrdata_q;
        burst_d  = burst_q;
        wr_d     = 1'b0;
        rd_d     = 1'b0;
        rd_ack_d = 1'b0;
        ready_c  = 1'b0;
        resp_c   = 1'b0;
        accept_c = 1'b0;

        case (state_q)
            ST_IDLE: begin
                ready_c = 1'b1;
            end
            ST_WR_ISSUE: begin
                wdata_d = hwdata_i;
                waddr_d = addr_q;
                wr_d    = 1'b1;
                cnt_d   = '0;
                state_d = ST_WR_WAIT;
            end
            ST_WR_WAIT: begin
                // An ack in the last timeout cycle still completes the write.
                if (wr_ack_i) begin
                    if (slv_error_i) begin
                        state_d = ST_ERR1;
                    end else begin
                        ready_c = 1'b1;
                        state_d = ST_IDLE;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_ERR1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RD: begin
                if (read_valid_i) begin
                    hrdata_d = rdata_i;
                    rd_ack_d = 1'b1;
                    state_d  = ST_IDLE;
                end else begin
                    state_d  = ST_ERR1;
                end
            end
            ST_ERR1: begin
                resp_c  = 1'b1;
                state_d = ST_ERR2;
            end
            ST_ERR2: begin
                resp_c  = 1'b1;
                ready_c = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Any cycle that completes with HREADYOUT high can take a new address.
        accept_c = hsel_i && hready_i && trans_c && ready_c;

        if (accept_c) begin
            burst_d = enc_burst(hburst_i);
            if (viol_c) begin
                state_d = ST_ERR1;
            end else if (hwrite_i) begin
                addr_d  = haddr_i;
                state_d = ST_WR_ISSUE;
            end else begin
                raddr_d  = haddr_i;
                rd_d     = 1'b1;
                hrdata_d = '0;
                state_d  = ST_RD;
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            addr_q   <= '0;
            waddr_q  <= '0;
            raddr_q  <= '0;
            wdata_q  <= '0;
            hrdata_q <= '0;
            burst_q  <= '0;
            wr_q     <= 1'b0;
            rd_q     <= 1'b0;
            rd_ack_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            waddr_q  <= waddr_d;
            raddr_q  <= raddr_d;
            wdata_q  <= wdata_d;
            hrdata_q <= hrdata_d;
            burst_q  <= burst_d;
            wr_q     <= wr_d;
            rd_q     <= rd_d;
            rd_ack_q <= rd_ack_d;
        end
    end

    // HREADYOUT follows wr_ack_i combinationally so a write completes in the ack cycle.
    assign hreadyout_o  = ready_c;
    assign hresp_o      = resp_c;
    assign hrdata_o     = hrdata_q;
    assign wr_o         = wr_q;
    assign waddr_o      = waddr_q;
    assign wdata_o      = wdata_q;
    assign rd_o         = rd_q;
    assign raddr_o      = raddr_q;
    assign rd_ack_o     = rd_ack_q;
    assign burst_type_o = burst_q;

    // Strobes are mutually exclusive single-cycle pulses.
    a_strobe_excl: assert property (@(posedge clk_i) disable iff (!resetn_i) !(wr_q && rd_q));
    a_wr_pulse:    assert property (@(posedge clk_i) disable iff (!resetn_i) wr_q |=> !wr_q);
    a_rd_pulse:    assert property (@(posedge clk_i) disable iff (!resetn_i) rd_q |=> !rd_q);

endmodule

// File: tb/tb_lw_sha_ahb_adapter.sv
// Directed bench for lw_sha_ahb_adapter: a vector table of single transfers,
// plus hand sequences for a pipelined INCR4 burst with BUSY and a reset
// dropped during a write wait.

module tb_lw_sha_ahb_adapter;

    localparam int unsigned W = 32;

    logic          clk_i = 1'b0;
    logic          resetn_i;
    logic          hsel_i;
    logic [11:0]   haddr_i;
    logic [1:0]    htrans_i;
    logic          hwrite_i;
    logic [2:0]    hsize_i;
    logic [2:0]    hburst_i;
    logic [W-1:0]  hwdata_i;
    logic          hready_i;
    logic          hreadyout_o;
    logic          hresp_o;
    logic [W-1:0]  hrdata_o;
    logic          wr_o;
    logic          wr_ack_i;
    logic [11:0]   waddr_o;
    logic [W-1:0]  wdata_o;
    logic          slv_error_i;
    logic          rd_o;
    logic [11:0]   raddr_o;
    logic [W-1:0]  rdata_i;
    logic          read_valid_i;
    logic          rd_ack_o;
    logic [1:0]    burst_type_o;

    always #5 clk_i = ~clk_i;

    lw_sha_ahb_adapter #(
        .FIQSHA_BUS_DATA_WIDTH (W),
        .ACK_TIMEOUT           (4)
    ) dut (
        .clk_i        (clk_i),
        .resetn_i     (resetn_i),
        .hsel_i       (hsel_i),
        .haddr_i      (haddr_i),
        .htrans_i     (htrans_i),
        .hwrite_i     (hwrite_i),
        .hsize_i      (hsize_i),
        .hburst_i     (hburst_i),
        .hwdata_i     (hwdata_i),
        .hready_i     (hready_i),
        .hreadyout_o  (hreadyout_o),
        .hresp_o      (hresp_o),
        .hrdata_o     (hrdata_o),
        .wr_o         (wr_o),
        .wr_ack_i     (wr_ack_i),
        .waddr_o      (waddr_o),
        .wdata_o      (wdata_o),
        .slv_error_i  (slv_error_i),
        .rd_o         (rd_o),
        .raddr_o      (raddr_o),
        .rdata_i      (rdata_i),
        .read_valid_i (read_valid_i),
        .rd_ack_o     (rd_ack_o),
        .burst_type_o (burst_type_o)
    );

    // Single-slave bus: the bus-wide ready is this slave's ready.
    assign hready_i = hreadyout_o;

    // Control block model: registered ack ack_dly cycles after wr_o (0 = never).
    int          ack_dly;
    int          ack_cd;
    logic        err_en;
    logic        rv_en;
    logic [W-1:0] rdata_val;

    always @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i)                  ack_cd <= 0;
        else if (wr_o && ack_dly > 0)   ack_cd <= ack_dly;
        else if (ack_cd > 0)            ack_cd <= ack_cd - 1;
    end

    assign wr_ack_i     = (ack_cd == 1);
    assign slv_error_i  = wr_ack_i & err_en;
    assign read_valid_i = rv_en;
    assign rdata_i      = rdata_val;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        wr;
        logic [11:0] addr;
        logic [2:0]  size;
        logic [2:0]  burst;
        logic [31:0] data;     // hwdata for writes, rdata_i for reads
        int          ack;      // wr_ack delay after wr_o, 0 = never
        logic        serr;
        logic        rv;
        int          e_cyc;    // data-phase cycles up to and including HREADYOUT=1
        logic        e_err;
        int          e_wr;
        int          e_rd;
        int          e_rdack;
        logic [1:0]  e_bt;
        logic        chk_rd;
        logic [31:0] e_rdata;
    } vec_t;

    vec_t vecs[12];

    // Per-transfer observations.
    int          r_cyc, r_rsp, r_wr, r_rd, r_rdack, both_cnt;
    logic        r_done, r_fin_rsp;
    logic [11:0] r_wa;
    logic [31:0] r_wd, r_rdata;

    task automatic do_xfer(input vec_t v);
        ack_dly   = v.ack;
        err_en    = v.serr;
        rv_en     = v.rv;
        rdata_val = v.wr ? 32'h0 : v.data;
        hsel_i    = 1'b1;
        htrans_i  = 2'b10;
        haddr_i   = v.addr;
        hwrite_i  = v.wr;
        hsize_i   = v.size;
        hburst_i  = v.burst;
        @(posedge clk_i); #1;
        hsel_i    = 1'b0;
        htrans_i  = 2'b00;
        hwdata_i  = v.wr ? v.data : 32'h0;
        r_cyc = 0; r_rsp = 0; r_wr = 0; r_rd = 0; r_rdack = 0;
        r_done = 1'b0; r_fin_rsp = 1'b0; r_wa = '0; r_wd = '0; r_rdata = '0;
        while (!r_done && r_cyc < 20) begin
            @(negedge clk_i);
            r_cyc++;
            if (hresp_o) r_rsp++;
            if (wr_o) begin r_wr++; r_wa = waddr_o; r_wd = wdata_o; end
            if (rd_o) r_rd++;
            if (wr_o && rd_o) both_cnt++;
            if (rd_ack_o) r_rdack++;
            if (hreadyout_o) begin
                r_done    = 1'b1;
                r_fin_rsp = hresp_o;
                r_rdata   = hrdata_o;
            end
            @(posedge clk_i); #1;
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, " hreadyout"}, 64'(hreadyout_o),  64'(1));
        check({tag, " hresp"},     64'(hresp_o),      64'(0));
        check({tag, " hrdata"},    64'(hrdata_o),     64'(0));
        check({tag, " wr"},        64'(wr_o),         64'(0));
        check({tag, " rd"},        64'(rd_o),         64'(0));
        check({tag, " rd_ack"},    64'(rd_ack_o),     64'(0));
        check({tag, " waddr"},     64'(waddr_o),      64'(0));
        check({tag, " raddr"},     64'(raddr_o),      64'(0));
        check({tag, " wdata"},     64'(wdata_o),      64'(0));
        check({tag, " burst"},     64'(burst_type_o), 64'(0));
    endtask

    typedef struct {
        logic [1:0]  tr;
        logic [11:0] addr;
        logic [31:0] data;
    } ph_t;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        ph_t         ph[5];
        int          idx, nwr, bt_bad, rsp_bad, busy_dp, strobes, notready;
        int          wr_at[4];
        logic [11:0] wr_a[4];
        logic [31:0] wr_d[4];
        logic        rdy, busy_rdy;

        //        wr    addr     sz    bst   data            ack serr rv  cyc err wr rd rda bt    chk   rdata
        vecs[0]  = '{1'b1, 12'h010, 3'd2, 3'd0, 32'h0000_0005, 1, 1'b0, 1'b1, 3, 1'b0, 1, 0, 0, 2'd0, 1'b0, 32'h0};
        vecs[1]  = '{1'b1, 12'h140, 3'd2, 3'd0, 32'h0000_A5A5, 1, 1'b1, 1'b1, 5, 1'b1, 1, 0, 0, 2'd0, 1'b0, 32'h0};
        vecs[2]  = '{1'b0, 12'h030, 3'd2, 3'd0, 32'h0000_0013, 0, 1'b0, 1'b1, 2, 1'b0, 0, 1, 1, 2'd0, 1'b1, 32'h0000_0013};
        vecs[3]  = '{1'b1, 12'h020, 3'd0, 3'd0, 32'h0000_0009, 1, 1'b0, 1'b1, 2, 1'b1, 0, 0, 0, 2'd0, 1'b0, 32'h0};
        vecs[4]  = '{1'b1, 12'h012, 3'd2, 3'd0, 32'h0000_0009, 1, 1'b0, 1'b1, 2, 1'b1, 0, 0, 0, 2'd0, 1'b0, 32'h0};
        vecs[5]  = '{1'b0, 12'h012, 3'd2, 3'd0, 32'h0000_0077, 0, 1'b0, 1'b1, 2, 1'b1, 0, 0, 0, 2'd0, 1'b0, 32'h0};
        vecs[6]  = '{1'b0, 12'h0F0, 3'd2, 3'd4, 32'hDEAD_BEEF, 0, 1'b0, 1'b0, 3, 1'b1, 0, 1, 0, 2'd3, 1'b1, 32'h0};
        vecs[7]  = '{1'b0, 12'h044, 3'd2, 3'd3, 32'h1234_5678, 0, 1'b0, 1'b1, 2, 1'b0, 0, 1, 1, 2'd2, 1'b1, 32'h1234_5678};
        vecs[8]  = '{1'b1, 12'h058, 3'd2, 3'd1, 32'h0000_CAFE, 0, 1'b0, 1'b1, 7, 1'b1, 1, 0, 0, 2'd1, 1'b0, 32'h0};
        vecs[9]  = '{1'b1, 12'h05C, 3'd2, 3'd2, 32'h0000_BEEF, 3, 1'b0, 1'b1, 5, 1'b0, 1, 0, 0, 2'd2, 1'b0, 32'h0};
        vecs[10] = '{1'b1, 12'h060, 3'd2, 3'd7, 32'h0000_600D, 4, 1'b0, 1'b1, 7, 1'b1, 1, 0, 0, 2'd3, 1'b0, 32'h0};
        vecs[11] = '{1'b0, 12'h0FC, 3'd2, 3'd5, 32'hFFFF_FFFF, 0, 1'b0, 1'b1, 2, 1'b0, 0, 1, 1, 2'd3, 1'b1, 32'hFFFF_FFFF};

        resetn_i = 1'b0; hsel_i = 1'b0; haddr_i = '0; htrans_i = 2'b00; hwrite_i = 1'b0;
        hsize_i = 3'd2; hburst_i = 3'd0; hwdata_i = '0;
        ack_dly = 1; err_en = 1'b0; rv_en = 1'b1; rdata_val = '0; both_cnt = 0;

        repeat (3) @(posedge clk_i);
        #1 resetn_i = 1'b1;
        @(posedge clk_i); #1;
        check_reset_vals("reset");

        // Table of single transfers.
        for (int i = 0; i < 12; i++) begin
            do_xfer(vecs[i]);
            check($sformatf("v%0d done", i),     64'(r_done),    64'(1));
            check($sformatf("v%0d cycles", i),   64'(r_cyc),     64'(vecs[i].e_cyc));
            check($sformatf("v%0d hresp", i),    64'(r_fin_rsp), 64'(vecs[i].e_err));
            check($sformatf("v%0d err_cyc", i),  64'(r_rsp),     64'(vecs[i].e_err ? 2 : 0));
            check($sformatf("v%0d wr_cnt", i),   64'(r_wr),      64'(vecs[i].e_wr));
            check($sformatf("v%0d rd_cnt", i),   64'(r_rd),      64'(vecs[i].e_rd));
            check($sformatf("v%0d rd_ack", i),   64'(r_rdack),   64'(vecs[i].e_rdack));
            check($sformatf("v%0d burst", i),    64'(burst_type_o), 64'(vecs[i].e_bt));
            if (vecs[i].e_wr == 1) begin
                check($sformatf("v%0d waddr", i), 64'(r_wa), 64'(vecs[i].addr));
                check($sformatf("v%0d wdata", i), 64'(r_wd), 64'(vecs[i].data));
            end
            if (vecs[i].chk_rd)
                check($sformatf("v%0d hrdata", i), 64'(r_rdata), 64'(vecs[i].e_rdata));
        end

        // Pipelined INCR4 write burst with a BUSY between beats 1 and 2.
        ph[0] = '{2'b10, 12'h100, 32'h1111_0000};
        ph[1] = '{2'b11, 12'h104, 32'h1111_0001};
        ph[2] = '{2'b01, 12'h108, 32'h0000_0000};
        ph[3] = '{2'b11, 12'h108, 32'h1111_0002};
        ph[4] = '{2'b11, 12'h10C, 32'h1111_0003};
        ack_dly = 1; err_en = 1'b0;
        idx = 0; nwr = 0; bt_bad = 0; rsp_bad = 0; busy_dp = -1; busy_rdy = 1'b0;
        for (int k = 0; k < 4; k++) begin wr_at[k] = -1; wr_a[k] = '0; wr_d[k] = '0; end
        hsel_i = 1'b1; hwrite_i = 1'b1; hsize_i = 3'd2; hburst_i = 3'd3;
        htrans_i = ph[0].tr; haddr_i = ph[0].addr;
        for (int c = 0; c < 18; c++) begin
            @(negedge clk_i);
            rdy = hreadyout_o;
            if (wr_o) begin
                if (nwr < 4) begin wr_at[nwr] = c; wr_a[nwr] = waddr_o; wr_d[nwr] = wdata_o; end
                nwr++;
            end
            if (wr_o && rd_o) both_cnt++;
            if (c > 0 && burst_type_o !== 2'd2) bt_bad++;
            if (hresp_o) rsp_bad++;
            if (c == busy_dp) busy_rdy = hreadyout_o;
            @(posedge clk_i); #1;
            if (rdy && idx < 5) begin
                if (ph[idx].tr == 2'b01) busy_dp = c + 1;
                else hwdata_i = ph[idx].data;
                idx++;
                if (idx < 5) begin
                    htrans_i = ph[idx].tr;
                    haddr_i  = ph[idx].addr;
                end else begin
                    htrans_i = 2'b00;
                    hsel_i   = 1'b0;
                end
            end
        end
        check("burst all phases accepted", 64'(idx),     64'(5));
        check("burst wr count",            64'(nwr),     64'(4));
        check("burst wr cycle 0", 64'(wr_at[0]), 64'(2));
        check("burst wr cycle 1", 64'(wr_at[1]), 64'(5));
        check("burst wr cycle 2", 64'(wr_at[2]), 64'(9));
        check("burst wr cycle 3", 64'(wr_at[3]), 64'(12));
        for (int k = 0; k < 4; k++) begin
            check($sformatf("burst waddr %0d", k), 64'(wr_a[k]), 64'(12'h100 + 12'(4 * k)));
            check($sformatf("burst wdata %0d", k), 64'(wr_d[k]), 64'(32'h1111_0000 + 32'(k)));
        end
        check("burst type held",     64'(bt_bad),   64'(0));
        check("burst no error",      64'(rsp_bad),  64'(0));
        check("busy zero-wait okay", 64'(busy_rdy), 64'(1));

        // Reset dropped while waiting for a write ack that never comes.
        ack_dly = 0;
        hsel_i = 1'b1; htrans_i = 2'b10; haddr_i = 12'h080; hwrite_i = 1'b1;
        hsize_i = 3'd2; hburst_i = 3'd1;
        @(posedge clk_i); #1;
        hsel_i = 1'b0; htrans_i = 2'b00; hwdata_i = 32'h0000_7777;
        @(posedge clk_i); #1;
        check("midrst wr issued", 64'(wr_o), 64'(1));
        @(posedge clk_i); #1;
        check("midrst waiting", 64'(hreadyout_o), 64'(0));
        #2 resetn_i = 1'b0;
        #1;
        check_reset_vals("midrst");
        @(posedge clk_i); #1;
        resetn_i = 1'b1;
        strobes = 0; notready = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk_i);
            if (wr_o || rd_o) strobes++;
            if (!hreadyout_o) notready++;
        end
        check("post-reset strobes",  64'(strobes),  64'(0));
        check("post-reset notready", 64'(notready), 64'(0));
        check("strobe exclusivity",  64'(both_cnt), 64'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/lw_sha_ahb_adapter.md
# lw_sha_ahb_adapter

AHB-Lite slave front end for the lightweight SHA/HMAC accelerator. It sits directly upstream of the SHA register/control block. It converts pipelined AHB-Lite transfers into that block's single-cycle `wr`/`rd` strobes, waits for the write acknowledge and read-valid handshakes, and drives `HREADYOUT`, `HRESP` and `HRDATA`. It also maps slave errors, protocol violations and acknowledge timeouts onto the two-cycle AHB ERROR response.

## Interface
Parameters:
- `FIQSHA_BUS_DATA_WIDTH`, default `` `FIQSHA_BUS `` (32): data bus width; must be 32 or 64.
- `ACK_TIMEOUT`, default 4: maximum number of cycles to wait for `wr_ack_i` before the write is errored.

Ports:
- `clk_i`  in  1  clock; all logic is on the rising edge.
- `resetn_i`  in  1  reset, asynchronous, active-low.
- `hsel_i`  in  1  slave select.
- `haddr_i`  in  12  byte address.
- `htrans_i`  in  2  transfer type: IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
- `hwrite_i`  in  1  1 = write.
- `hsize_i`  in  3  transfer size.
- `hburst_i`  in  3  burst type.
- `hwdata_i`  in  W  write data, valid in the data phase.
- `hready_i`  in  1  bus-wide ready.
- `hreadyout_o`  out  1  slave ready.
- `hresp_o`  out  1  0 = OKAY, 1 = ERROR.
- `hrdata_o`  out  W  read data.
- `wr_o`  out  1  one-cycle write strobe to the control block.
- `wr_ack_i`  in  1  write acknowledge; arrives registered, one cycle after `wr_o`.
- `waddr_o`  out  12  write address.
- `wdata_o`  out  W  write data.
- `slv_error_i`  in  1  write rejected; sampled in the same cycle as `wr_ack_i`.
- `rd_o`  out  1  read request.
- `raddr_o`  out  12  read address.
- `rdata_i`  in  W  read data; combinational from `rd_o`/`raddr_o`.
- `read_valid_i`  in  1  read address decoded; combinational.
- `rd_ack_o`  out  1  one-cycle read-complete pulse.
- `burst_type_o`  out  2  encoded burst of the current transfer.

## Operation
- **Address-phase capture:** a transfer is accepted when `hsel_i & hready_i & htrans_i[1]`. The adapter then registers address, direction, size and `hburst_i`.
- **BUSY and IDLE:** transfers with `htrans_i` = BUSY or IDLE are not captured and receive a zero-wait OKAY.
- **Protocol check:** a captured transfer with `hsize_i != $clog2(W/8)`, or with address bits below the word size nonzero, goes straight to ERROR. No `wr_o` or `rd_o` is issued.
- **`burst_type_o` encoding:** SINGLE→0; INCR→1; INCR4 or WRAP4→2; all other bursts→3. The value is held from capture until the next capture.
- **FSM states:** IDLE, WR_ISSUE, WR_WAIT, RD, ERR1, ERR2.
- **IDLE:**
  - Accepted write → WR_ISSUE.
  - Accepted read → RD.
  - Protocol violation → ERR1.
- **WR_ISSUE:**
  - Register `hwdata_i` into `wdata_o`.
  - Next cycle, pulse `wr_o` for exactly one cycle with `waddr_o` = captured address, and go to WR_WAIT.
- **WR_WAIT:** a timeout counter starts at 0.
  - `wr_ack_i & !slv_error_i` → OKAY and return to IDLE.
  - `wr_ack_i & slv_error_i` → ERR1.
  - Counter reaches `ACK_TIMEOUT` → ERR1.
  - A `wr_ack_i` arriving after the timeout is ignored.
- **RD:**
  - Drive `rd_o=1` and `raddr_o` for one cycle.
  - If `read_valid_i` is high, register `rdata_i` into `hrdata_o`, then pulse `rd_ack_o` with `hreadyout_o=1` next cycle.
  - If `read_valid_i` is low, go to ERR1 and leave `hrdata_o` at 0.
- **ERR1:** `hresp_o=1`, `hreadyout_o=0`.
- **ERR2:** `hresp_o=1`, `hreadyout_o=1`, then IDLE.
- **Pipelining:** in any cycle with `hreadyout_o=1` (OKAY completion, ERR2, or IDLE), a new address phase may be captured in the same cycle. This gives back-to-back transfers.
- **Stall behaviour:** while `hreadyout_o=0`, address-phase inputs are ignored.
- **`hrdata_o` after reads:** holds its value after a read completes and is cleared at the start of every read.

## Timing
- **Reset values:**
  - `hreadyout_o=1`
  - `hresp_o=0`
  - `hrdata_o=0`
  - `wr_o=0`, `rd_o=0`, `rd_ack_o=0`
  - `waddr_o=0`, `raddr_o=0`, `wdata_o=0`
  - `burst_type_o=0`
  - FSM in IDLE, timeout counter at 0.
- **Reset mid-transfer:** immediate return to reset values. No pending `wr_o` or `rd_o` is emitted after release.
- **Write, from address phase A:**
  - D=A+1: `hreadyout_o=0`.
  - D+1: `wr_o=1`.
  - D+2: `wr_ack_i` arrives and `hreadyout_o=1`.
  - Total: 3 data-phase cycles.
- **Read:**
  - D: `rd_o=1`.
  - D+1: `hreadyout_o=1`, `hrdata_o` valid, `rd_ack_o=1`.
  - Total: 2 data-phase cycles.
- **Errors:** always exactly two cycles (ERR1, ERR2), starting the cycle after detection.
- **Write timeout:** `ERR1` is entered `ACK_TIMEOUT` cycles after `wr_o`.
- **Simultaneous acknowledge and timeout:** if `wr_ack_i` arrives in the same cycle the timeout expires, the acknowledge wins.
- **Strobe exclusivity:** `wr_o` and `rd_o` are never high together, and each is high for at most one cycle per transfer.

## Test plan
- **Single write:** write 0x0000_0005 to 0x010, with `wr_ack_i` one cycle after `wr_o` → `wr_o` high 1 cycle, `waddr_o`=0x010, `wdata_o`=5; OKAY after 3 data-phase cycles; `burst_type_o`=0.
- **Rejected write:** write to 0x140 with `slv_error_i=1` alongside `wr_ack_i` → `hresp_o`=1 for 2 cycles, `hreadyout_o` 0 then 1.
- **Reads:**
  - Read 0x030 with `rdata_i`=0x0000_0013 → `hrdata_o`=0x13 at D+1 and `rd_ack_o` pulses once.
  - Read 0x0F0 with `read_valid_i=0` → ERROR and `hrdata_o`=0.
- **INCR4 burst:** write 0x100–0x10C → 4 `wr_o` pulses at increasing addresses, `burst_type_o`=2 throughout, no gaps beyond the 3-cycle write latency; a BUSY mid-burst gets a zero-wait OKAY.
- **Protocol and timeout:**
  - `hsize_i`=0 or `haddr_i`=0x012 → ERROR with no strobe.
  - `wr_ack_i` held low → ERROR 4 cycles after `wr_o`.
- **Reset mid-operation:** drop `resetn_i` during WR_WAIT → all outputs at reset values immediately, and no strobe after release.
